pipeline_hazard_ctrl: RTL and testbench

Central pipeline control for the 5-stage core. Produces the jump/flush flag and hold signals that the fetch, IF/ID and ID/EX delay registers consume. Arbitrates three sources:
- branch/jump resolution from EX
- multi-cycle busy from EX
- load-use hazards between ID and the ID/EX register outputs

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_if.sv | 40 ++++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, the hard-wired zero register index and the default address width.
package pipeline_hazard_ctrl_pkg;

    localparam int         ADDR_WIDTH_DEF = 32;
    localparam logic [4:0] REG_ZERO       = 5'd0;

    typedef enum logic {
        CTRL_IDLE  = 1'b0,
        CTRL_FLUSH = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bus between the pipeline stages and the hazard controller.
// master: the pipeline side (reports EX/ID status, consumes flush/hold).
// slave : the hazard controller.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  ctrl_jump_req_in;
    logic [ADDR_WIDTH-1:0] ctrl_jump_addr_in;
    logic                  ctrl_ex_busy_in;
    logic                  ctrl_ex_is_load_in;
    logic                  ctrl_ex_wen_in;
    logic [4:0]            ctrl_ex_write_addr_in;
    logic [4:0]            ctrl_id_reg1_addr_in;
    logic [4:0]            ctrl_id_reg2_addr_in;
    logic                  ctrl_jump_flag_out;
    logic [ADDR_WIDTH-1:0] ctrl_jump_addr_out;
    logic                  ctrl_hold_pc_out;
    logic                  ctrl_hold_ifd_out;
    logic                  ctrl_hold_idd_out;
    logic                  ctrl_bubble_out;

    modport master (
        output ctrl_jump_req_in, ctrl_jump_addr_in, ctrl_ex_busy_in,
               ctrl_ex_is_load_in, ctrl_ex_wen_in, ctrl_ex_write_addr_in,
               ctrl_id_reg1_addr_in, ctrl_id_reg2_addr_in,
        input  ctrl_jump_flag_out, ctrl_jump_addr_out, ctrl_hold_pc_out,
               ctrl_hold_ifd_out, ctrl_hold_idd_out, ctrl_bubble_out
    );

    modport slave (
        input  ctrl_jump_req_in, ctrl_jump_addr_in, ctrl_ex_busy_in,
               ctrl_ex_is_load_in, ctrl_ex_wen_in, ctrl_ex_write_addr_in,
               ctrl_id_reg1_addr_in, ctrl_id_reg2_addr_in,
        output ctrl_jump_flag_out, ctrl_jump_addr_out, ctrl_hold_pc_out,
               ctrl_hold_ifd_out, ctrl_hold_idd_out, ctrl_bubble_out
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: the load sitting in ID/EX writes a register that
// the instruction in ID reads. Writes to x0 are discarded and never stall.
module hazard_load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       is_load,
    input  logic       wen,
    input  logic [4:0] write_addr,
    input  logic [4:0] reg1_addr,
    input  logic [4:0] reg2_addr,
    output logic       hazard
);

    assign hazard = is_load && wen && (write_addr != REG_ZERO) &&
                    ((write_addr == reg1_addr) || (write_addr == reg2_addr));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline control for the 5-stage core: flush on taken jumps,
// freeze on EX busy, one-cycle bubble on load-use. Priority jump > busy >
// load-use. Optional macro PIPELINE_HAZARD_CTRL_PERF_EN adds saturating
// stall/flush cycle counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]           ctrl_stall_cnt_out,
    output logic [31:0]           ctrl_flush_cnt_out
`endif
);

    ctrl_state_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  load_use;
    logic                  flag;
    logic                  hold_pc;

    hazard_load_use_detect u_load_use (
        .is_load    (bus.ctrl_ex_is_load_in),
        .wen        (bus.ctrl_ex_wen_in),
        .write_addr (bus.ctrl_ex_write_addr_in),
        .reg1_addr  (bus.ctrl_id_reg1_addr_in),
        .reg2_addr  (bus.ctrl_id_reg2_addr_in),
        .hazard     (load_use)
    );

    // State, flush counter and saved jump target registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CTRL_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Next state: a jump (re)starts the flush window from any state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        if (bus.ctrl_jump_req_in) begin
            addr_d = bus.ctrl_jump_addr_in;
            if (FLUSH_CYCLES > 1) begin
                state_d = CTRL_FLUSH;
                cnt_d   = 4'(FLUSH_CYCLES - 1);
            end else begin
                state_d = CTRL_IDLE;
                cnt_d   = '0;
            end
        end else if (state_q == CTRL_FLUSH) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = CTRL_IDLE;
            end
        end
    end

    // Outputs: flush dominates, then busy freeze, then load-use bubble
    always_comb begin
        flag                  = bus.ctrl_jump_req_in || (state_q == CTRL_FLUSH);
        bus.ctrl_jump_addr_out = bus.ctrl_jump_req_in ? bus.ctrl_jump_addr_in : addr_q;
        hold_pc               = 1'b0;
        bus.ctrl_hold_ifd_out = 1'b0;
        bus.ctrl_hold_idd_out = 1'b0;
        bus.ctrl_bubble_out   = 1'b0;
        if (!flag) begin
            if (bus.ctrl_ex_busy_in) begin
                hold_pc               = 1'b1;
                bus.ctrl_hold_ifd_out = 1'b1;
                bus.ctrl_hold_idd_out = 1'b1;
            end else if (load_use) begin
                hold_pc               = 1'b1;
                bus.ctrl_hold_ifd_out = 1'b1;
                bus.ctrl_bubble_out   = 1'b1;
            end
        end
    end

    assign bus.ctrl_jump_flag_out = flag;
    assign bus.ctrl_hold_pc_out   = hold_pc;

`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating counts of stalled and flushing cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hold_pc) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (flag)    flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign ctrl_stall_cnt_out = stall_cnt_q;
    assign ctrl_flush_cnt_out = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed sequences, a table
// of single-cycle IDLE vectors and randomized traffic against a reference model.
module tb_pipeline_hazard_ctrl;

    localparam int FC = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipeline_hazard_ctrl_if #(.ADDR_WIDTH(32)) bus_if ();

`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
        ,
        .ctrl_stall_cnt_out (stall_cnt),
        .ctrl_flush_cnt_out (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       busy;
        logic       ld;
        logic       wen;
        logic [4:0] wa;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       epc;
        logic       eifd;
        logic       eidd;
        logic       ebub;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic jr, input logic [31:0] ja, input logic busy,
                          input logic ld, input logic wen, input logic [4:0] wa,
                          input logic [4:0] r1, input logic [4:0] r2);
        bus_if.ctrl_jump_req_in      = jr;
        bus_if.ctrl_jump_addr_in     = ja;
        bus_if.ctrl_ex_busy_in       = busy;
        bus_if.ctrl_ex_is_load_in    = ld;
        bus_if.ctrl_ex_wen_in        = wen;
        bus_if.ctrl_ex_write_addr_in = wa;
        bus_if.ctrl_id_reg1_addr_in  = r1;
        bus_if.ctrl_id_reg2_addr_in  = r2;
    endtask

    task automatic chk_out(input string tag, input logic ef, input logic [31:0] ea,
                           input logic epc, input logic eifd, input logic eidd,
                           input logic ebub);
        check({tag, "_flag"}, 32'(bus_if.ctrl_jump_flag_out), 32'(ef));
        check({tag, "_addr"}, bus_if.ctrl_jump_addr_out, ea);
        check({tag, "_hold_pc"}, 32'(bus_if.ctrl_hold_pc_out), 32'(epc));
        check({tag, "_hold_ifd"}, 32'(bus_if.ctrl_hold_ifd_out), 32'(eifd));
        check({tag, "_hold_idd"}, 32'(bus_if.ctrl_hold_idd_out), 32'(eidd));
        check({tag, "_bubble"}, 32'(bus_if.ctrl_bubble_out), 32'(ebub));
    endtask

    // advance one clock; inputs are then driven 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // reference model state
    int          left_m;
    logic [31:0] saved_m;
    int unsigned stall_m;
    int unsigned flush_m;

    function automatic logic lu_ref(input logic ld, input logic wen, input logic [4:0] wa,
                                    input logic [4:0] r1, input logic [4:0] r2);
        if (!(ld && wen) || wa == 0) return 1'b0;
        return (wa == r1) || (wa == r2);
    endfunction

    initial begin
        logic        jr, busy, ld, wen;
        logic [31:0] ja;
        logic [4:0]  wa, r1, r2;
        logic        ef, epc, eifd, eidd, ebub, lu;
        logic [31:0] ea;

        checks = 0;
        errors = 0;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 5'd6, 5'd5, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset, then idle for 10 cycles
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #2 chk_out("idle", 0, 32'h0, 0, 0, 0, 0);
            tick();
        end
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
        check("perf_stall_reset", stall_cnt, 32'd0);
        check("perf_flush_reset", flush_cnt, 32'd0);
`endif

        // busy for 4 cycles with a coincident load-use condition
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 1, 1, 1, 5'd3, 5'd3, 5'd0);
            #2 chk_out("busy", 0, 32'h0, 1, 1, 1, 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 5'd3, 5'd3, 5'd0);
        #2 chk_out("busy_done", 0, 32'h0, 0, 0, 0, 0);
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
        check("perf_stall_busy", stall_cnt, 32'd4);
`endif
        tick();

        // single jump to 0x100
        set_in(1, 32'h100, 0, 0, 0, 0, 0, 0);
        #2 chk_out("jump_c0", 1, 32'h100, 0, 0, 0, 0);
        tick();
        set_in(0, 32'hDEAD, 0, 0, 0, 0, 0, 0);
        #2 chk_out("jump_c1", 1, 32'h100, 0, 0, 0, 0);
        tick();
        #2 chk_out("jump_c2", 0, 32'h100, 0, 0, 0, 0);
        tick();

        // load-use: one bubble, then the load has left ID/EX
        set_in(0, 0, 0, 1, 1, 5'd5, 5'd1, 5'd5);
        #2 chk_out("lu_stall", 0, 32'h100, 1, 1, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd5);
        #2 chk_out("lu_clear", 0, 32'h100, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        #2 chk_out("lu_x0", 0, 32'h100, 0, 0, 0, 0);
        tick();

        // jump wins over busy and load-use; second jump during FLUSH reloads
        set_in(1, 32'h300, 1, 1, 1, 5'd2, 5'd2, 5'd2);
        #2 chk_out("jbl_c0", 1, 32'h300, 0, 0, 0, 0);
        tick();
        set_in(1, 32'h200, 1, 0, 0, 0, 0, 0);
        #2 chk_out("jbl_c1", 1, 32'h200, 0, 0, 0, 0);
        tick();
        set_in(0, 32'h0, 1, 0, 0, 0, 0, 0);
        #2 chk_out("jbl_c2", 1, 32'h200, 0, 0, 0, 0);
        tick();
        #2 chk_out("jbl_c3", 0, 32'h200, 1, 1, 1, 0);
        tick();

        // reset asserted mid-FLUSH drops the flag without a clock edge
        set_in(1, 32'h440, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 32'h0, 0, 0, 0, 0, 0, 0);
        #2 check("rstf_before", 32'(bus_if.ctrl_jump_flag_out), 32'd1);
        rst = 1'b0;
        #1 check("rstf_async_flag", 32'(bus_if.ctrl_jump_flag_out), 32'd0);
        check("rstf_async_addr", bus_if.ctrl_jump_addr_out, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        #2 chk_out("rstf_after", 0, 32'h0, 0, 0, 0, 0);
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
        check("perf_stall_rst2", stall_cnt, 32'd0);
        check("perf_flush_rst2", flush_cnt, 32'd0);
`endif
        tick();

        // table of single-cycle IDLE vectors
        for (int i = 0; i < 9; i++) begin
            set_in(0, 0, tbl[i].busy, tbl[i].ld, tbl[i].wen, tbl[i].wa, tbl[i].r1, tbl[i].r2);
            #2 chk_out($sformatf("tbl%0d", i), 0, 32'h0, tbl[i].epc, tbl[i].eifd,
                       tbl[i].eidd, tbl[i].ebub);
            tick();
        end

        // randomized traffic against the reference model
        do_reset();
        left_m  = 0;
        saved_m = 0;
        stall_m = 0;
        flush_m = 0;
        for (int i = 0; i < 400; i++) begin
            jr   = ($urandom_range(0, 7) == 0);
            ja   = $urandom;
            busy = ($urandom_range(0, 3) == 0);
            ld   = 1'($urandom_range(0, 1));
            wen  = 1'($urandom_range(0, 1));
            wa   = 5'($urandom_range(0, 3));
            r1   = 5'($urandom_range(0, 3));
            r2   = 5'($urandom_range(0, 3));
            set_in(jr, ja, busy, ld, wen, wa, r1, r2);

            ef   = jr || (left_m > 0);
            ea   = jr ? ja : saved_m;
            lu   = lu_ref(ld, wen, wa, r1, r2);
            epc  = !ef && (busy || lu);
            eifd = epc;
            eidd = !ef && busy;
            ebub = !ef && !busy && lu;
            #2 chk_out("rand", ef, ea, epc, eifd, eidd, ebub);
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
            check("rand_perf_stall", stall_cnt, stall_m);
            check("rand_perf_flush", flush_cnt, flush_m);
`endif
            tick();

            if (epc) stall_m++;
            if (ef)  flush_m++;
            if (jr) begin
                saved_m = ja;
                left_m  = FC - 1;
            end else if (left_m > 0) begin
                left_m--;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
